// File: rtl/fc_act_buffer_if.sv
// Stream-in / vector-out bundle of the activation buffer: element stream from
// upstream plus the parallel vector handed to the fully-connected layer.
interface fc_act_buffer_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IN    = 128
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic [WIDTH-1:0] x [0:IN-1];
  logic             x_valid;
  logic             x_ready;

  // Upstream producer and downstream layer together form the master side.
  modport master (
    output in_valid, in_data, in_last, x_ready,
    input  in_ready, x, x_valid
  );

  modport slave (
    input  in_valid, in_data, in_last, x_ready,
    output in_ready, x, x_valid
  );
endinterface

// File: rtl/fc_act_buffer.sv
// Serial-to-parallel activation collector: assembles an IN-element vector from
// a valid/ready element stream and holds it for the layer until acknowledged.
module fc_act_buffer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IN    = 128,
  parameter int unsigned FCW   = 16
) (
  input  logic           clk,
  input  logic           rst,
  fc_act_buffer_if.slave bus,
  output logic           err,
  output logic [FCW-1:0] frame_cnt
);

  localparam int unsigned IW = (IN > 1) ? $clog2(IN) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(IN - 1);

  typedef enum logic {FILL, FULL} state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] x_r [0:IN-1];
  logic             in_ready_r;
  logic             x_valid_r;
  logic             accept;
  logic             at_last;

  assign accept  = bus.in_valid && in_ready_r;
  assign at_last = (idx == LAST_IDX);

  assign bus.x        = x_r;
  assign bus.in_ready = in_ready_r;
  assign bus.x_valid  = x_valid_r;

  // Fill/hold state machine; a vector closes on in_last or on the IN-th element.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FILL;
      idx        <= '0;
      x_r        <= '{default: '0};
      in_ready_r <= 1'b1;
      x_valid_r  <= 1'b0;
      err        <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      err <= 1'b0;
      if (state == FILL) begin
        if (accept) begin
          // Short vectors zero the unwritten tail so x is always fully defined.
          for (int i = 0; i < int'(IN); i++) begin
            if (IW'(i) == idx)
              x_r[i] <= bus.in_data;
            else if (bus.in_last && (IW'(i) > idx))
              x_r[i] <= '0;
          end
          if (at_last || bus.in_last) begin
            state      <= FULL;
            idx        <= '0;
            in_ready_r <= 1'b0;
            x_valid_r  <= 1'b1;
            err        <= bus.in_last ^ at_last;
          end else begin
            idx <= idx + IW'(1);
          end
        end
      end else begin
        if (bus.x_ready) begin
          state      <= FILL;
          idx        <= '0;
          in_ready_r <= 1'b1;
          x_valid_r  <= 1'b0;
          frame_cnt  <= frame_cnt + FCW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fc_act_buffer.sv
// Scoreboard bench for fc_act_buffer: the driver queues the expected vector when
// it issues a vector's closing element; a negedge monitor checks every handoff.
module tb_fc_act_buffer;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned IN    = 128;
  localparam int unsigned FCW   = 16;

  typedef logic [IN-1:0][WIDTH-1:0] vec_t;
  typedef struct packed {
    vec_t           vec;
    logic           err;
    logic [FCW-1:0] frame;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           err;
  logic [FCW-1:0] frame_cnt;

  fc_act_buffer_if #(.WIDTH(WIDTH), .IN(IN)) bus ();

  fc_act_buffer #(.WIDTH(WIDTH), .IN(IN), .FCW(FCW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .err       (err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t exp_q [$];

  // Reference model state
  vec_t           m_vec;
  int             m_idx;
  logic [FCW-1:0] m_frame;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t pack_x();
    vec_t v;
    for (int i = 0; i < int'(IN); i++) v[i] = bus.x[i];
    return v;
  endfunction

  function automatic int first_diff(input vec_t a, input vec_t b);
    for (int i = 0; i < int'(IN); i++) if (a[i] !== b[i]) return i;
    return -1;
  endfunction

  task automatic chk_vec(input string name, input vec_t act, input vec_t exp);
    int d;
    d = first_diff(act, exp);
    n_chk++;
    if (d >= 0) begin
      n_fail++;
      $display("FAIL %s: x[%0d] got 0x%0h expected 0x%0h at %0t", name, d, act[d], exp[d], $time);
    end
  endtask

  task automatic model_reset();
    m_vec   = '0;
    m_idx   = 0;
    m_frame = '0;
  endtask

  // Drive one element and wait for it to be accepted; model records it.
  task automatic send(input logic [WIDTH-1:0] d, input logic last);
    int cyc;
    exp_t e;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    cyc = 0;
    while (!bus.in_ready && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!bus.in_ready) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    m_vec[m_idx] = d;
    if (last || m_idx == int'(IN) - 1) begin
      e.vec   = m_vec;
      e.err   = last ^ (m_idx == int'(IN) - 1);
      e.frame = m_frame;
      exp_q.push_back(e);
      m_vec = '0;
      m_idx = 0;
    end else begin
      m_idx++;
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int cyc;
    cyc = 0;
    while (!bus.x_valid && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk(name, 32'(bus.x_valid), 32'd1);
  endtask

  task automatic handoff(input string name);
    bus.x_ready = 1'b1;
    @(posedge clk); #1;
    bus.x_ready = 1'b0;
    m_frame = m_frame + FCW'(1);
    chk({name, "_xvalid"}, 32'(bus.x_valid), 32'd0);
    chk({name, "_inready"}, 32'(bus.in_ready), 32'd1);
    chk({name, "_frame"}, 32'(frame_cnt), 32'(m_frame));
  endtask

  // Monitor: pops on each rising x_valid, otherwise checks stability and quiet err.
  logic prev_v = 1'b0;
  vec_t snap;
  always @(negedge clk) begin
    vec_t cur;
    exp_t e;
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      cur = pack_x();
      if (bus.x_valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_vector", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk_vec("sb_vec", cur, e.vec);
          chk("sb_err", 32'(err), 32'(e.err));
          chk("sb_frame", 32'(frame_cnt), 32'(e.frame));
          chk("sb_inready_full", 32'(bus.in_ready), 32'd0);
        end
        snap = cur;
      end else begin
        chk("err_idle", 32'(err), 32'd0);
        if (bus.x_valid) chk_vec("x_stable", cur, snap);
      end
      prev_v = bus.x_valid;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    bus.x_ready  = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("rst_xvalid", 32'(bus.x_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_frame", 32'(frame_cnt), 32'd0);
    chk("rst_inready", 32'(bus.in_ready), 32'd1);
    chk_vec("rst_x", pack_x(), '0);

    // Full vector, in_last on the final element
    for (int i = 0; i < int'(IN); i++) send(WIDTH'(i - 64), (i == int'(IN) - 1));
    idle();
    wait_valid("t1_valid");
    chk("t1_x0", 32'(bus.x[0]), 32'h0000_00C0);
    chk("t1_x127", 32'(bus.x[IN-1]), 32'h0000_003F);
    chk("t1_inready", 32'(bus.in_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    handoff("t2");

    // Short vector
    for (int i = 1; i <= 5; i++) send(WIDTH'(i), (i == 5));
    idle();
    wait_valid("t3_valid");
    chk("t3_x4", 32'(bus.x[4]), 32'd5);
    chk("t3_x5", 32'(bus.x[5]), 32'd0);
    handoff("t3");

    // Missing in_last
    for (int i = 0; i < int'(IN); i++) send(WIDTH'(i) ^ 8'h5A, 1'b0);
    idle();
    wait_valid("t4_valid");

    // Back-pressure while FULL
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = WIDTH'(8'hA0 + i);
      bus.in_last  = i[0];
      @(posedge clk); #1;
      chk("t5_inready", 32'(bus.in_ready), 32'd0);
    end
    idle();
    handoff("t4");

    // Next element after the missing-last vector lands in x[0]
    send(8'h07, 1'b0);
    send(8'hF8, 1'b0);
    send(8'h09, 1'b1);
    idle();
    wait_valid("t5_valid");
    chk("t5_x0", 32'(bus.x[0]), 32'h07);
    chk("t5_x1", 32'(bus.x[1]), 32'hF8);
    handoff("t5");

    // Asynchronous reset mid-fill
    for (int i = 0; i < 60; i++) send(WIDTH'(i + 1), 1'b0);
    #3 rst = 1'b1;
    #1;
    chk("t6_xvalid", 32'(bus.x_valid), 32'd0);
    chk("t6_frame", 32'(frame_cnt), 32'd0);
    v = pack_x();
    chk_vec("t6_x_clear", v, '0);
    model_reset();
    idle();
    @(negedge clk) rst = 1'b0;
    #1;
    chk("t6_inready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < int'(IN); i++) begin
      send(WIDTH'(3 * i + 1), (i == int'(IN) - 1));
      if (i == int'(IN) - 2) chk("t6_not_early", 32'(bus.x_valid), 32'd0);
    end
    idle();
    wait_valid("t6_valid");
    handoff("t6");

    repeat (4) @(posedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
